// File: rtl/slot_packer_pkg.sv
// Shared constants and types for the slot packer: word width, idle filler value,
// pack FSM state encoding and statistics counter width.
package slot_packer_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] IDLE_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int STATS_W = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/slot_packer_skid.sv
// Show-ahead skid FIFO for the slot packer; pointers carry one extra wrap bit so
// count spans 0..DEPTH. A write while full is legal only together with a read.
module slot_packer_skid
    import slot_packer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic [PTR_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/slot_packer.sv
// Packs non-idle words into WORDS_PER_LINE-word lines through a skid FIFO.
// Define SLOT_PACKER_STATS_EN to add the lines_out / words_dropped counters.
module slot_packer
    import slot_packer_pkg::*;
#(
    parameter int                WORDS_PER_LINE = 4,
    parameter int                SKID_DEPTH     = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD      = IDLE_WORD_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [WORD_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             stall,
    input  logic                             flush,
    output logic [WORD_W*WORDS_PER_LINE-1:0] line_data,
    output logic [WORDS_PER_LINE-1:0]        line_mask,
    output logic                             line_valid,
    input  logic                             line_ready,
    output logic                             overflow
`ifdef SLOT_PACKER_STATS_EN
    ,
    output logic [STATS_W-1:0]               lines_out,
    output logic [STATS_W-1:0]               words_dropped
`endif
);

    localparam int PTR_W = $clog2(SKID_DEPTH) + 1;
    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [PTR_W:0]   STALL_LVL = (PTR_W + 1)'(SKID_DEPTH - 1);

    pack_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              accept, pop, wr_en, drop;
    logic [WORD_W-1:0] rd_data;
    logic [PTR_W-1:0]  count;
    logic              full, empty;
    logic [PTR_W:0]    next_count;

    assign accept = in_valid && (in_data != IDLE_WORD);
    assign pop    = (state == FILL) && !empty;
    assign wr_en  = accept && (!full || pop);
    assign drop   = accept && full && !pop;
    assign next_count = {1'b0, count} + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};

    slot_packer_skid #(.DEPTH(SKID_DEPTH)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Line handshake: a line transfers on any edge where line_valid && line_ready;
    // line_valid, line_data and line_mask never change while a line waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            idx        <= '0;
            line_valid <= 1'b0;
            line_mask  <= '0;
            line_data  <= '0;
            stall      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            stall <= (next_count >= STALL_LVL) ||
                     ((state == HOLD) && !line_ready && (next_count != '0));
            if (drop) overflow <= 1'b1;
            case (state)
                FILL: begin
                    if (pop) begin
                        line_data[idx*WORD_W +: WORD_W] <= rd_data;
                        line_mask[idx] <= 1'b1;
                    end
                    if ((pop && idx == LAST_IDX) || (flush && idx != '0)) begin
                        idx        <= '0;
                        line_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (pop) begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (line_ready) begin
                        line_valid <= 1'b0;
                        line_mask  <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef SLOT_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_out     <= '0;
            words_dropped <= '0;
        end else begin
            if (line_valid && line_ready && lines_out != '1) lines_out <= lines_out + 1'b1;
            if (drop && words_dropped != '1) words_dropped <= words_dropped + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_slot_packer.sv
// Bench for slot_packer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_slot_packer;

    localparam int WPL   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = WPL * 32;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          stall;
    logic          flush = 1'b0;
    logic [LW-1:0] line_data;
    logic [WPL-1:0] line_mask;
    logic          line_valid;
    logic          line_ready = 1'b1;
    logic          overflow;
`ifdef SLOT_PACKER_STATS_EN
    logic [15:0]   lines_out, words_dropped;
`endif

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;

    always #5 clk = ~clk;

    slot_packer #(.WORDS_PER_LINE(WPL), .SKID_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .line_data  (line_data),
        .line_mask  (line_mask),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .overflow   (overflow)
`ifdef SLOT_PACKER_STATS_EN
        ,
        .lines_out     (lines_out),
        .words_dropped (words_dropped)
`endif
    );

    // Reference model: skid contents and the line under construction as queues.
    logic [31:0]    exp_q[$];
    logic [31:0]    cur_q[$];
    logic [LW-1:0]  got_data[$];
    logic [WPL-1:0] got_mask[$];
    bit             m_hold, m_valid, m_stall, m_ovf;
    logic [LW-1:0]  m_data;
    logic [WPL-1:0] m_mask;
    int             m_lines, m_drops;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc, pop, wr, drop, fl_ok;
        int n;
        if (reset) begin
            exp_q.delete(); cur_q.delete();
            m_hold = 0; m_valid = 0; m_stall = 0; m_ovf = 0;
            m_data = '0; m_mask = '0; m_lines = 0; m_drops = 0;
            return;
        end
        acc  = in_valid && (in_data != IDLE);
        pop  = !m_hold && (exp_q.size() > 0);
        wr   = acc && (exp_q.size() < DEPTH || pop);
        drop = acc && !wr;
        n = exp_q.size() + int'(wr) - int'(pop);
        m_stall = (n >= DEPTH - 1) || (m_hold && !line_ready && n >= 1);
        if (drop) begin
            m_ovf = 1;
            if (m_drops < 16'hFFFF) m_drops++;
        end
        if (m_hold) begin
            if (line_ready) begin
                got_data.push_back(m_data);
                got_mask.push_back(m_mask);
                if (m_lines < 16'hFFFF) m_lines++;
                m_hold = 0; m_valid = 0; m_mask = '0;
            end
        end else begin
            fl_ok = flush && (cur_q.size() > 0);
            if (pop) cur_q.push_back(exp_q.pop_front());
            if (cur_q.size() == WPL || fl_ok) begin
                for (int i = 0; i < cur_q.size(); i++) m_data[i*32 +: 32] = cur_q[i];
                m_mask = WPL'((1 << cur_q.size()) - 1);
                cur_q.delete();
                m_hold = 1; m_valid = 1;
            end
        end
        if (wr) exp_q.push_back(in_data);
    endtask

    task automatic compare();
        logic [WPL-1:0] em;
        logic [LW-1:0]  dm;
        em = m_hold ? m_mask : WPL'((1 << cur_q.size()) - 1);
        chk("line_valid", 256'(line_valid), 256'(m_valid));
        chk("line_mask", 256'(line_mask), 256'(em));
        chk("stall", 256'(stall), 256'(m_stall));
        chk("overflow", 256'(overflow), 256'(m_ovf));
        if (m_valid) begin
            dm = '0;
            for (int i = 0; i < WPL; i++) if (m_mask[i]) dm[i*32 +: 32] = '1;
            chk("line_data", 256'(line_data & dm), 256'(m_data & dm));
        end
`ifdef SLOT_PACKER_STATS_EN
        chk("lines_out", 256'(lines_out), 256'(m_lines));
        chk("words_dropped", 256'(words_dropped), 256'(m_drops));
`endif
        if (line_valid === 1'b1) vcnt++;
    endtask

    always @(posedge clk) begin
        model_step();
        #1 compare();
    end

    // Driver tasks: inputs change on the falling edge only.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1; in_data = w; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_log();
        got_data.delete(); got_mask.delete(); vcnt = 0;
    endtask

    initial begin
        logic [LW-1:0] ln;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_line_data", 256'(line_data), 256'(0));
        chk("reset_valid_mask", 256'({line_valid, line_mask, stall, overflow}), 256'(0));

        // Four words with the sink ready: one full line, stall never rises.
        clear_log();
        line_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i));
        idle(6);
        chk("t1_lines", 256'(got_data.size()), 256'(1));
        ln = {32'd4, 32'd3, 32'd2, 32'd1};
        if (got_data.size() > 0) begin
            chk("t1_data", 256'(got_data[0]), 256'(ln));
            chk("t1_mask", 256'(got_mask[0]), 256'(4'b1111));
        end
        chk("t1_valid_cycles", 256'(vcnt), 256'(1));

        // Idle filler words are never accepted.
        clear_log();
        repeat (10) send(IDLE);
        idle(2);
        chk("t2_state", 256'({line_valid, stall, overflow}), 256'(0));
        chk("t2_lines", 256'(got_data.size()), 256'(0));

        // Blocked sink: one held line, four skidded words, the rest dropped.
        clear_log();
        line_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(32'hA000_0000 + 32'(i));
        idle(2);
        chk("t3_overflow", 256'(overflow), 256'(1));
        chk("t3_stall", 256'(stall), 256'(1));
        @(negedge clk);
        line_ready = 1'b1;
        idle(12);
        chk("t3_lines", 256'(got_data.size()), 256'(2));
        if (got_data.size() == 2) begin
            ln = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
            chk("t3_line0", 256'(got_data[0]), 256'(ln));
            ln = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004};
            chk("t3_line1", 256'(got_data[1]), 256'(ln));
        end
        do_reset();
        chk("t3_ovf_cleared", 256'(overflow), 256'(0));

        // Flush emits a partial line; flush with nothing packed is ignored.
        clear_log();
        send(32'd5); send(32'd6);
        idle(2);
        @(negedge clk); flush = 1'b1;
        idle(4);
        chk("t4_lines", 256'(got_data.size()), 256'(1));
        if (got_data.size() > 0) begin
            chk("t4_mask", 256'(got_mask[0]), 256'(4'b0011));
            chk("t4_data", 256'(got_data[0][63:0]), 256'({32'd6, 32'd5}));
        end
        @(negedge clk); flush = 1'b1;
        idle(4);
        chk("t4_empty_flush", 256'(got_data.size()), 256'(1));

        // Reset mid-line discards the partial line.
        clear_log();
        send(32'h11); send(32'h22);
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h30 + 32'(i));
        idle(6);
        chk("t5_lines", 256'(got_data.size()), 256'(1));
        if (got_data.size() > 0) chk("t5_mask", 256'(got_mask[0]), 256'(4'b1111));

`ifdef SLOT_PACKER_STATS_EN
        do_reset();
        line_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(32'h100 + 32'(i));
        @(negedge clk); line_ready = 1'b1;
        idle(12);
        for (int i = 0; i < 4; i++) send(32'h200 + 32'(i));
        idle(6);
        chk("t6_lines_out", 256'(lines_out), 256'(3));
        chk("t6_words_dropped", 256'(words_dropped), 256'(2));
`endif

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = ($urandom_range(0, 7) == 0) ? IDLE : $urandom;
            line_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; line_ready = 1'b1;
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_packer.md
Name: slot_packer

Overview:
- Downstream consumer of the slot buffer stage.
- Accepts 32-bit words on a valid strobe and discards idle filler words.
- Absorbs in-flight words in a small skid FIFO and packs them into WORDS_PER_LINE-word lines for a valid/ready sink.
- Drives the stall input of the buffer stage so that words are parked in its slots while the packer is backed up.

Parameters:
WORDS_PER_LINE, 4, words per output line (2..8)
SKID_DEPTH, 4, skid FIFO entries (>=2, power of two)
IDLE_WORD, 32'hFFFFFFFF, filler value never accepted as data

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_data  in  32  word from buffer stage
in_valid  in  1  in_data qualifier; one strobe per word
stall  out  1  to buffer stage; registered
flush  in  1  pulse: emit partial line
line_data  out  32*WORDS_PER_LINE  packed line; word 0 in bits [31:0]
line_mask  out  WORDS_PER_LINE  bit i = word i valid
line_valid  out  1  line available
line_ready  in  1  sink accepts line
overflow  out  1  sticky: word dropped, skid full

Behaviour:
- Accept condition: in_valid && in_data != IDLE_WORD. Evaluated every cycle, regardless of stall.
- Accepted word is written to the skid FIFO at the clock edge.
- If the skid FIFO is full: the word is dropped and overflow is set. overflow clears only on reset.
- Skid occupancy range is 0..SKID_DEPTH. Pointer width is log2(SKID_DEPTH)+1; pointers wrap naturally.
- Simultaneous write and pop on the same edge: occupancy is unchanged. This is legal even when the FIFO is full, because the pop frees the entry first.
- stall register next value = (next occupancy >= SKID_DEPTH-1) || (state==HOLD && !line_ready && next occupancy >= 1). This leaves one entry of headroom for a word already in flight.
- Pack FSM states:
  - FILL:
    - Pops one word per cycle when the FIFO is non-empty.
    - The popped word goes to slot idx and sets line_mask[idx]; idx increments.
    - If the pop fills slot WORDS_PER_LINE-1: idx returns to 0, line_valid=1, go to HOLD.
    - If flush && idx>0 with no pop this cycle: line_valid=1, go to HOLD with the partial mask.
    - If flush && idx>0 with a pop this cycle: the pop lands first, then go to HOLD.
    - flush with idx==0 and no pop is ignored.
  - HOLD:
    - line_data, line_mask and line_valid are held stable; no pops occur.
    - When line_valid && line_ready: line_valid=0, mask cleared, go to FILL. The next pop can happen in the cycle after the handshake.
    - flush is ignored in HOLD.
- Latency: a word accepted at edge N is popped at edge N+1 if in FILL. line_valid rises at the edge that pops the last word.
- Reset values: stall=0, line_valid=0, line_mask=0, line_data=0, overflow=0, idx=0, skid empty, state FILL.
- Reset mid-line: the partial line and all skid contents are discarded; no line is emitted.
- Back-to-back lines: the minimum spacing is WORDS_PER_LINE+1 cycles between line_valid rises.

Optional Feature:
- Macro: SLOT_PACKER_STATS_EN
- Defined:
  - Adds output lines_out[15:0], incremented on each line handshake.
  - Adds output words_dropped[15:0], incremented on each overflow drop.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package slot_packer_pkg:
  - IDLE_WORD_DEFAULT constant.
  - Pack state enum {FILL, HOLD}.
  - WORD_W=32 constant.
  - Stats counter width constant (16).
- Sub-module slot_packer_skid:
  - Parameterised SKID_DEPTH FIFO.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Show-ahead read.
  - Top level holds the FSM, line register, stall logic and stats.

Test Plan:
1. Reset, then in_valid with words 1,2,3,4 on consecutive cycles, line_ready=1 -> exactly one line: line_data={4,3,2,1}, mask 4'b1111, line_valid high for 1 cycle; stall stays 0.
2. in_valid=1 with in_data=32'hFFFFFFFF for 10 cycles -> nothing accepted; line_valid=0, stall=0, overflow=0.
3. 12 back-to-back words A0..A11 with line_ready=0 -> first line is held; stall asserts once occupancy reaches 3; no more than 4 words are skidded; extra strobes set overflow. Release line_ready -> lines A0..A3, then A4..A7.
4. Words 5,6 then a flush pulse -> line {x,x,6,5} with mask 4'b0011. A later flush with idx==0 emits nothing.
5. Reset asserted after 2 of 4 words -> no line emitted; the next 4 words form a clean line with mask 4'b1111.
6. With SLOT_PACKER_STATS_EN: 3 full lines plus 2 forced drops -> lines_out=3, words_dropped=2. Preload at 16'hFFFF -> the counter holds 16'hFFFF.
